// File: rtl/status_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | status_frame_pkg : shared tags, 7-seg constants and state encodings   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package status_frame_pkg;

  localparam logic [7:0] c_tag_a = 8'h61;
  localparam logic [7:0] c_tag_b = 8'h62;
  localparam logic [7:0] c_tag_c = 8'h63;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    GET_LED = 3'd1,
    WAIT_B  = 3'd2,
    GET_BUZ = 3'd3,
    WAIT_C  = 3'd4,
    GET_SEG = 3'd5
  } parser_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // LED and buzzer bytes carry a single boolean: only 0x00 or 0x01.
  function automatic logic is_flag(input logic [7:0] b);
    return (b[7:1] == 7'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_8n1 : 8N1 UART byte receiver with input synchronizer          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module uart_rx_8n1
  import status_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] c_half = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] c_full = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  rx_state_e   state_q;
  logic        sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      rxbyte     <= 8'd0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !sync2_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (cnt_q == c_half) begin
            cnt_q <= '0;
            bit_q <= 3'd0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + c_one;
          end
        end
        RX_DATA: begin
          if (cnt_q == c_full) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= RX_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + c_one;
          end
        end
        RX_STOP: begin
          if (cnt_q == c_full) begin
            state_q <= RX_IDLE;
            if (sync2_q) begin
              byte_valid <= 1'b1;
              rxbyte     <= shift_q;
            end else begin
              byte_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + c_one;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/status_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | status_frame_rx : UART status-frame parser with byte/link timeouts    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module status_frame_rx
  import status_frame_pkg::*;
#(
  parameter int CLK_HZ            = 50_000_000,
  parameter int BAUD              = 115200,
  parameter int BYTE_TIMEOUT_CLKS = 50_000,
  parameter int LINK_TIMEOUT_CLKS = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic       led,
  output logic       buzzer,
  output logic [6:0] seg7,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       link_ok
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BW = $clog2(BYTE_TIMEOUT_CLKS + 1);
  localparam int LW = $clog2(LINK_TIMEOUT_CLKS + 1);
  localparam logic [BW-1:0] c_byte_max = BW'(BYTE_TIMEOUT_CLKS - 1);
  localparam logic [LW-1:0] c_link_max = LW'(LINK_TIMEOUT_CLKS - 1);
  localparam logic [BW-1:0] c_byte_one = BW'(1);
  localparam logic [LW-1:0] c_link_one = LW'(1);

  logic [7:0] w_rxbyte;
  logic       w_byte_valid, w_byte_err;
  logic       w_legal, w_byte_to, w_link_to;

  parser_state_e state_q;
  logic          led_tmp_q, buz_tmp_q;
  logic [BW-1:0] byte_cnt_q;
  logic [LW-1:0] link_cnt_q;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx_pin),
    .rxbyte     (w_rxbyte),
    .byte_valid (w_byte_valid),
    .byte_err   (w_byte_err)
  );

  always_comb begin
    w_legal = 1'b0;
    case (state_q)
      WAIT_A:           w_legal = (w_rxbyte == c_tag_a);
      GET_LED, GET_BUZ: w_legal = is_flag(w_rxbyte);
      WAIT_B:           w_legal = (w_rxbyte == c_tag_b);
      WAIT_C:           w_legal = (w_rxbyte == c_tag_c);
      GET_SEG:          w_legal = !w_rxbyte[7];
      default:          w_legal = 1'b0;
    endcase
  end

  // Both counters saturate at their limit so an expiry masked by a
  // coincident byte_valid is still acted on one cycle later.
  assign w_byte_to = (state_q != WAIT_A) && (byte_cnt_q == c_byte_max);
  assign w_link_to = link_ok && (link_cnt_q == c_link_max);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_A;
      led_tmp_q   <= 1'b0;
      buz_tmp_q   <= 1'b0;
      byte_cnt_q  <= '0;
      link_cnt_q  <= '0;
      led         <= 1'b0;
      buzzer      <= 1'b0;
      seg7        <= SEG_0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      link_ok     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (w_byte_valid || state_q == WAIT_A) byte_cnt_q <= '0;
      else if (!w_byte_to)                   byte_cnt_q <= byte_cnt_q + c_byte_one;

      if (!link_ok)        link_cnt_q <= '0;
      else if (!w_link_to) link_cnt_q <= link_cnt_q + c_link_one;

      if (w_byte_valid) begin
        if (w_legal) begin
          case (state_q)
            WAIT_A:  state_q <= GET_LED;
            GET_LED: begin led_tmp_q <= w_rxbyte[0]; state_q <= WAIT_B; end
            WAIT_B:  state_q <= GET_BUZ;
            GET_BUZ: begin buz_tmp_q <= w_rxbyte[0]; state_q <= WAIT_C; end
            WAIT_C:  state_q <= GET_SEG;
            GET_SEG: begin
              led         <= led_tmp_q;
              buzzer      <= buz_tmp_q;
              seg7        <= w_rxbyte[6:0];
              frame_valid <= 1'b1;
              link_ok     <= 1'b1;
              link_cnt_q  <= '0;
              state_q     <= WAIT_A;
            end
            default: state_q <= WAIT_A;
          endcase
        end else if (state_q != WAIT_A) begin
          frame_err <= 1'b1;
          state_q   <= ((w_rxbyte == c_tag_a) &&
                        (state_q == WAIT_B || state_q == WAIT_C)) ? GET_LED : WAIT_A;
        end
      end else if (w_byte_err || w_byte_to || w_link_to) begin
        frame_err <= 1'b1;
        if (w_byte_err || w_byte_to) state_q <= WAIT_A;
        if (w_link_to) begin
          link_ok <= 1'b0;
          led     <= 1'b0;
          buzzer  <= 1'b0;
          seg7    <= SEG_0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_status_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_status_frame_rx : randomized + directed bench with frame model     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_status_frame_rx;

  localparam int BIT       = 16;
  localparam int GAP       = 24;
  localparam int BYTE_TO   = 400;
  localparam int LINK_TO   = 6000;
  localparam int BYTE_CLKS = BIT * 10 + GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic       led, buzzer, frame_valid, frame_err, link_ok;
  logic [6:0] seg7;

  status_frame_rx #(
    .CLK_HZ(160), .BAUD(10),
    .BYTE_TIMEOUT_CLKS(BYTE_TO), .LINK_TIMEOUT_CLKS(LINK_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin),
    .led(led), .buzzer(buzzer), .seg7(seg7),
    .frame_valid(frame_valid), .frame_err(frame_err), .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int fv_seen = 0, fe_seen = 0;

  always @(negedge clk) begin
    if (frame_valid) fv_seen++;
    if (frame_err)   fe_seen++;
  end

  // Reference model: position within the 6-byte frame plus pending fields.
  int         m_pos = 0, m_fv = 0, m_fe = 0;
  int         m_since_frame = 0, m_since_byte = 0;
  logic       m_led = 0, m_buz = 0, m_link = 0, f_led = 0, f_buz = 0;
  logic [6:0] m_seg = 7'b0000001;

  function automatic bit field_ok(int pos, logic [7:0] b);
    case (pos)
      0:       return b == 8'h61;
      1, 3:    return b < 8'd2;
      2:       return b == 8'h62;
      4:       return b == 8'h63;
      default: return b < 8'd128;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    m_since_byte = 0;
    if (field_ok(m_pos, b)) begin
      if (m_pos == 1) f_led = b[0];
      if (m_pos == 3) f_buz = b[0];
      if (m_pos == 5) begin
        m_led = f_led; m_buz = f_buz; m_seg = b[6:0];
        m_link = 1; m_fv++; m_since_frame = 0;
      end
      m_pos = (m_pos + 1) % 6;
    end else if (m_pos != 0) begin
      m_fe++;
      m_pos = (b == 8'h61 && (m_pos == 2 || m_pos == 4)) ? 1 : 0;
    end
  endtask

  task automatic model_advance(input int n);
    m_since_frame += n;
    m_since_byte  += n;
    if (m_pos != 0 && m_since_byte > BYTE_TO) begin m_fe++; m_pos = 0; end
    if (m_link && m_since_frame > LINK_TO) begin
      m_link = 0; m_led = 0; m_buz = 0; m_seg = 7'b0000001; m_fe++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".led"},    led,     m_led);
    check({tag, ".buzzer"}, buzzer,  m_buz);
    check({tag, ".seg7"},   seg7,    m_seg);
    check({tag, ".link"},   link_ok, m_link);
    check({tag, ".nvalid"}, fv_seen, m_fv);
    check({tag, ".nerr"},   fe_seen, m_fe);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input string tag);
    rx_pin = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (BIT) @(posedge clk);
    end
    rx_pin = stop;
    repeat (BIT) @(posedge clk);
    rx_pin = 1'b1;
    repeat (GAP) @(posedge clk);
    if (stop) model_byte(b);
    else begin m_fe++; m_pos = 0; end
    model_advance(BYTE_CLKS);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic send_frame(input logic l, input logic z, input logic [6:0] s, input string tag);
    send_byte(8'h61, 1'b1, tag); send_byte({7'd0, l}, 1'b1, tag);
    send_byte(8'h62, 1'b1, tag); send_byte({7'd0, z}, 1'b1, tag);
    send_byte(8'h63, 1'b1, tag); send_byte({1'b0, s}, 1'b1, tag);
  endtask

  task automatic idle(input int n, input string tag);
    rx_pin = 1'b1;
    repeat (n) @(posedge clk);
    model_advance(n);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] nb;
    int         nn;

    repeat (4) @(posedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");
    check("reset.fv_pin", frame_valid, 0);
    check("reset.fe_pin", frame_err, 0);

    send_frame(1'b1, 1'b1, 7'b1001111, "frame1");
    check("frame1.seg_one", seg7, 7'b1001111);

    send_byte(8'h00, 1'b1, "noise"); send_byte(8'hFF, 1'b1, "noise");
    send_byte(8'h37, 1'b1, "noise");
    send_frame(1'b0, 1'b0, 7'b0000001, "frame0");

    send_byte(8'h61, 1'b1, "badled"); send_byte(8'h02, 1'b1, "badled");
    send_byte(8'h61, 1'b1, "badbuz"); send_byte(8'h01, 1'b1, "badbuz");
    send_byte(8'h62, 1'b1, "badbuz"); send_byte(8'h62, 1'b1, "badbuz");
    send_frame(1'b1, 1'b0, 7'h61, "seg61");
    check("seg61.seg", seg7, 7'b1100001);

    send_byte(8'h61, 1'b1, "stop0"); send_byte(8'h01, 1'b1, "stop0");
    send_byte(8'h62, 1'b1, "stop0"); send_byte(8'h01, 1'b0, "stop0");
    send_byte(8'h62, 1'b1, "waita"); send_byte(8'h01, 1'b1, "waita");
    send_byte(8'h63, 1'b1, "waita"); send_byte(8'h05, 1'b1, "waita");

    send_byte(8'h61, 1'b1, "glitch");
    rx_pin = 1'b0;
    repeat (4) @(posedge clk);
    rx_pin = 1'b1;
    model_advance(4);
    idle(100, "glitch");
    send_byte(8'h01, 1'b1, "glitch"); send_byte(8'h62, 1'b1, "glitch");
    send_byte(8'h01, 1'b1, "glitch"); send_byte(8'h63, 1'b1, "glitch");
    send_byte(8'h05, 1'b1, "glitch");

    send_byte(8'h61, 1'b1, "bto"); send_byte(8'h01, 1'b1, "bto");
    idle(500, "bto");
    send_frame(1'b0, 1'b1, 7'h2A, "after_bto");

    for (int it = 0; it < 12; it++) begin
      nn = $urandom_range(0, 4);
      for (int k = 0; k < nn; k++) begin
        case ($urandom_range(0, 6))
          0: nb = 8'h00;
          1: nb = 8'h01;
          2: nb = 8'h61;
          3: nb = 8'h62;
          4: nb = 8'h63;
          5: nb = 8'hFF;
          default: nb = 8'($urandom);
        endcase
        send_byte(nb, 1'b1, "rnd_noise");
      end
      if (m_pos != 0) send_byte(8'hFF, 1'b1, "rnd_flush");
      send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 7'($urandom_range(0, 127)), "rnd_frame");
    end

    idle(6500, "lto");
    check("lto.seg_safe", seg7, 7'b0000001);

    send_byte(8'h61, 1'b1, "rstmid"); send_byte(8'h01, 1'b1, "rstmid");
    send_byte(8'h62, 1'b1, "rstmid"); send_byte(8'h01, 1'b1, "rstmid");
    send_byte(8'h63, 1'b1, "rstmid");
    rx_pin = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_pin = 1'(i & 1);
      repeat (BIT) @(posedge clk);
    end
    rst_n = 1'b0;
    rx_pin = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    m_pos = 0; m_led = 0; m_buz = 0; m_seg = 7'b0000001; m_link = 0;
    m_since_frame = 0; m_since_byte = 0;
    idle(50, "rstmid");
    send_frame(1'b1, 1'b0, 7'h3F, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/status_frame_rx.md
STATUS_FRAME_RX -- requirements
Module: status_frame_rx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults).
REQ-003 The block SHALL have parameter BYTE_TIMEOUT_CLKS, default 50_000, meaning the maximum idle gap between bytes of one frame.
REQ-004 The block SHALL have parameter LINK_TIMEOUT_CLKS, default 50_000_000, meaning the maximum gap between valid frames before the link is declared lost.
REQ-005 clk  input  1  system clock; all logic is on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 rx_pin  input  1  asynchronous UART 8N1 serial line, idle high.
REQ-008 led  output  1  remote LED state from the last accepted frame.
REQ-009 buzzer  output  1  remote buzzer state from the last accepted frame.
REQ-010 seg7  output  7  remote 7-segment pattern (a-g, active-low) from the last accepted frame.
REQ-011 frame_valid  output  1  one-cycle pulse when a complete valid frame is accepted.
REQ-012 frame_err  output  1  one-cycle pulse on any framing, content or timeout error.
REQ-013 link_ok  output  1  high while valid frames arrive within LINK_TIMEOUT_CLKS.

Function
REQ-014 rx_pin SHALL pass through a two-flop synchronizer before use.
REQ-015 The byte receiver SHALL detect a start bit on a high-to-low transition and re-sample it at CLKS_PER_BIT/2; if the re-sample is high, it SHALL abort silently and return to idle.
REQ-016 The receiver SHALL sample 8 data bits LSB-first at bit centres, then the stop bit; stop=1 yields a one-cycle byte_valid with the byte, and stop=0 yields a one-cycle byte_err with no byte_valid.
REQ-017 The parser SHALL accept the 6-byte frame 0x61 'a', LED, 0x62 'b', BUZ, 0x63 'c', SEG, in that order.
REQ-018 Parser states SHALL be WAIT_A, GET_LED, WAIT_B, GET_BUZ, WAIT_C, GET_SEG; each byte_valid advances one state when the byte is legal.
REQ-019 LED and BUZ bytes SHALL be legal only as 0x00 or 0x01, and the SEG byte only with bit7=0.
REQ-020 In WAIT_A, a byte other than 0x61 SHALL be discarded without frame_err.
REQ-021 In any other state, an illegal byte SHALL pulse frame_err; the parser SHALL go to GET_LED if the byte is 0x61 and is received in WAIT_B or WAIT_C (resync), and to WAIT_A otherwise.
REQ-022 byte_err in any state SHALL pulse frame_err and force WAIT_A.
REQ-023 In any state other than WAIT_A, BYTE_TIMEOUT_CLKS clocks with no byte_valid SHALL pulse frame_err and force WAIT_A; the counter SHALL restart on every byte_valid.
REQ-024 led, buzzer and seg7 SHALL update atomically, and frame_valid SHALL pulse, on the clock edge after the legal SEG byte_valid; partial frames SHALL never alter outputs.
REQ-025 link_ok SHALL go high with frame_valid; LINK_TIMEOUT_CLKS clocks without frame_valid SHALL clear link_ok and force led=0, buzzer=0, seg7=7'b0000001.
REQ-026 If byte_err or timeout coincides with byte_valid, only byte_valid SHALL be acted on; if both timeouts expire on the same cycle, a single frame_err pulse SHALL be produced.

Reset
REQ-027 With rst_n low at a clock edge, outputs SHALL be led=0, buzzer=0, seg7=7'b0000001, frame_valid=0, frame_err=0, link_ok=0.
REQ-028 With rst_n low at a clock edge, the receiver SHALL return to idle, the parser to WAIT_A, and all counters to 0, aborting any byte or frame in progress.

Structure
REQ-029 The shared package status_frame_pkg SHALL hold the tag constants 0x61/0x62/0x63, SEG_0 = 7'b0000001, SEG_1 = 7'b1001111, and the parser state encoding.
REQ-030 The byte receiver SHALL be the sub-module uart_rx_8n1 (clk, rst_n, rx, rxbyte, byte_valid, byte_err), the counterpart of uart_tx_8n1; the parser, timeouts and output registers SHALL live in status_frame_rx.

Verification (bench overrides CLK_HZ=160, BAUD=10, i.e. 16 clks/bit, with small timeouts)
REQ-031 Frame 61 01 62 01 63 4F -> one frame_valid; led=1, buzzer=1, seg7=1001111; link_ok=1; no frame_err.
REQ-032 Noise 00 FF 37 followed by a valid frame 61 00 62 00 63 01 -> no frame_err; outputs 0/0/0000001.
REQ-033 Sequence 61 02 -> frame_err at byte 2, outputs unchanged; then 61 01 62 62 -> frame_err; then 61 01 62 00 63 61 -> accepted, seg7=1100001.
REQ-034 Stop bit driven 0 on the BUZ byte -> frame_err, parser in WAIT_A; a 4-clk low glitch on rx_pin -> no byte is received.
REQ-035 Sending 61 01 then idling BYTE_TIMEOUT_CLKS -> frame_err; idling LINK_TIMEOUT_CLKS after a valid frame -> link_ok=0 and outputs at safe values.
REQ-036 rst_n pulsed low mid-byte during GET_SEG -> all outputs at reset values; the next full frame is accepted normally.
